// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin sharing of an async FIFO read port among NREQ consumers; RD_ARB_PRIO0_EN gives consumer 0 strict priority
module fifo_rd_arbiter #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4
) (
  input  logic             rclk_i,
  input  logic             rrst_n_i,
  input  logic             rempty_i,
  input  logic [DSIZE-1:0] rdata_i,
  output logic             rinc_o,
  input  logic [NREQ-1:0]  req_i,
  input  logic [NREQ-1:0]  ready_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [NREQ-1:0]  dvalid_o,
  output logic [DSIZE-1:0] dout_o,
  output logic             busy_o
);
  localparam int CW = $clog2(BURST) + 1;
  localparam int PW = $clog2(NREQ);
`ifdef RD_ARB_PRIO0_EN
  localparam logic PRIO0 = 1'b1;
`else
  localparam logic PRIO0 = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_e;
  state_e           state_q;
  logic [NREQ-1:0]  gnt_q, dvalid_q, pick_d;
  logic [DSIZE-1:0] dout_q;
  logic [PW-1:0]    ptr_q, gidx, k;
  logic [CW-1:0]    cnt_q;
  logic             req_g, rdy_g, out_free, found;
  assign req_g    = |(req_i & gnt_q);
  assign rdy_g    = |(ready_i & gnt_q);
  assign out_free = ~|dvalid_q | rdy_g;
  assign rinc_o   = (state_q == XFER) & req_g & ~rempty_i & (cnt_q < CW'(BURST)) & out_free;
  assign gnt_o    = gnt_q;
  assign dvalid_o = dvalid_q;
  assign dout_o   = dout_q;
  assign busy_o   = state_q != IDLE;
  // first requester at or after ptr with wrap; consumer 0 overrides in priority builds
  always_comb begin
    pick_d = '0;
    found  = 1'b0;
    k      = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = PW'((int'(ptr_q) + i) % NREQ);
      if (!found && req_i[k]) begin
        pick_d[k] = 1'b1;
        found     = 1'b1;
      end
    end
    if (PRIO0 && req_i[0]) pick_d = NREQ'(1);
  end
  // index of the one-hot grant, used to advance the rotating pointer
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) if (gnt_q[i]) gidx = PW'(i);
  end
  // arbitration FSM with the registered output stage
  always_ff @(posedge rclk_i or negedge rrst_n_i) begin
    if (!rrst_n_i) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      dvalid_q <= '0;
      dout_q   <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (|req_i) begin
          gnt_q   <= pick_d;
          cnt_q   <= '0;
          state_q <= XFER;
        end
        XFER: begin
          if (rinc_o) begin
            dout_q   <= rdata_i;
            dvalid_q <= gnt_q;
            cnt_q    <= cnt_q + CW'(1);
          end else if (rdy_g) dvalid_q <= '0;
          if ((rinc_o && cnt_q == CW'(BURST - 1)) || !req_g) state_q <= RELEASE;
        end
        RELEASE: if (out_free) begin
          dvalid_q <= '0;
          gnt_q    <= '0;
          cnt_q    <= '0;
          if (!PRIO0 || gidx != '0) ptr_q <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
